// File: rtl/cla_serial_subtractor_pkg.sv
// Shared arithmetic definitions for the serial carry-lookahead subtractor:
// slice width, FSM state encoding and the slice-count helper.
package cla_serial_subtractor_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int num_slices(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla_slice_4b.sv
// Purely combinational 4-bit carry-lookahead adder slice.
// All carries are flat sum-of-products terms of g, p and ci, so there is no ripple path.
module cla_slice_4b
    import cla_serial_subtractor_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:1] c;

    assign g = x & y;
    assign p = x ^ y;

    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ {c[3:1], ci};
    assign co = c[4];

endmodule

// File: rtl/cla_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, computed as a + ~b + ~bin one
// 4-bit lookahead slice per clock (LSB first), with borrow/overflow/zero flags.
module cla_serial_subtractor
    import cla_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int N     = num_slices(WIDTH);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   bn_q, bn_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [SLICE_W-1:0] slice_x, slice_y, slice_s;
    logic               slice_co;

    // One slice adder is shared by all slice positions; the counter picks the operand nibbles.
    always_comb begin
        slice_x = '0;
        slice_y = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                slice_x = a_q[i*SLICE_W +: SLICE_W];
                slice_y = bn_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    cla_slice_4b u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        a_d       = a_q;
        bn_d      = bn_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    bn_d    = ~b;
                    carry_d = ~bin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (cnt_q == CNT_W'(i)) diff_d[i*SLICE_W +: SLICE_W] = slice_s;
                end
                carry_d = slice_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // bn_q holds ~b, so the subtrahend sign is its inverted MSB.
                    bout_d  = ~slice_co;
                    ovf_d   = (a_q[WIDTH-1] != ~bn_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d  = (diff_d == '0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            bn_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            bn_q    <= bn_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_cla_serial_subtractor.sv
// Scoreboard bench for cla_serial_subtractor (WIDTH=16): expected results come
// from a wide-integer reference model and are popped when out_valid rises.
module tb_cla_serial_subtractor;

    localparam int W = 16;
    localparam int N = 4;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    cla_serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        res_t         r;
        logic [W:0]   full;
        full   = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
        r.diff = full[W-1:0];
        r.bout = full[W];
        r.ovf  = (av[W-1] != bv[W-1]) && (r.diff[W-1] != av[W-1]);
        r.zero = (r.diff == '0);
        return r;
    endfunction

    // One operation: accept, wait for the result, hold it for 'hold' cycles, consume.
    // With poke set, junk operands with in_valid=1 are driven while the block is busy.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                          input int hold, input logic poke);
        res_t e;
        res_t got;
        int   lat;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready got=%b exp=1", in_ready);
        end
        a         = av;
        b         = bv;
        bin       = bi;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        exp_q.push_back(model(av, bv, bi));
        @(posedge clk);
        @(negedge clk);
        in_valid = poke;
        a        = 16'($urandom);
        b        = 16'($urandom);
        bin      = 1'($urandom);
        lat      = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != N) begin
            bad++;
            $display("FAIL latency got=%0d exp=%0d", lat, N);
        end
        e   = exp_q.pop_front();
        got = '{diff, bout, ovf, zero};
        total++;
        if (got.diff !== e.diff) begin
            bad++;
            $display("FAIL diff a=%h b=%h bin=%b got=%h exp=%h", av, bv, bi, got.diff, e.diff);
        end
        total++;
        if ({got.bout, got.ovf, got.zero} !== {e.bout, e.ovf, e.zero}) begin
            bad++;
            $display("FAIL flags a=%h b=%h bin=%b got(bout,ovf,zero)=%b%b%b exp=%b%b%b",
                     av, bv, bi, got.bout, got.ovf, got.zero, e.bout, e.ovf, e.zero);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL done_in_ready got=%b exp=0", in_ready);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            got = '{diff, bout, ovf, zero};
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== e) begin
                bad++;
                $display("FAIL hold_stable cyc=%0d got(ov,ir,res)=%b,%b,%h exp=1,0,%h",
                         h, out_valid, in_ready, got, e);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        got = '{diff, bout, ovf, zero};
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || got !== e) begin
            bad++;
            $display("FAIL consume got(ov,ir,res)=%b,%b,%h exp=0,1,%h", out_valid, in_ready, got, e);
        end
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #4;
        total++;
        if ({in_ready, out_valid, diff, bout, ovf, zero} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
            bad++;
            $display("FAIL reset got(ir,ov,diff,b,o,z)=%b,%b,%h,%b,%b,%b exp=1,0,0000,0,0,0",
                     in_ready, out_valid, diff, bout, ovf, zero);
        end
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_out_ready got(ov,ir)=%b,%b exp=0,1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_arith();
        run_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0);
        run_op(16'h0005, 16'h0004, 1'b1, 0, 1'b0);
        run_op(16'h0000, 16'hFFFF, 1'b1, 0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b0, 1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op(16'h1234, 16'h0234, 1'b0, 3, 1'b1);
        run_op(16'hABCD, 16'h1234, 1'b1, 0, 1'b0);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        a        = 16'hFFFF;
        b        = 16'h1234;
        bin      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== '0 || {bout, ovf, zero} !== 3'b000) begin
            bad++;
            $display("FAIL abort got(ov,ir,diff,flags)=%b,%b,%h,%b%b%b exp=0,1,0000,000",
                     out_valid, in_ready, diff, bout, ovf, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 0, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
